// File: rtl/ahb_master_arbiter_if.sv
// ahb_master_arbiter_if
//
// Bundles the per-master AHB request/address/data signals, the grant
// outputs and the bridge-facing muxed signals that connect the master
// arbiter to up to four AHB masters and to the AHB-to-APB bridge.
//
// Modports
//   slave  : the arbiter side. It takes the masters' requests and bus
//            signals plus Hready, and drives grants and the muxed bus.
//   master : the masters'/environment side, the mirror image of slave.
//
// Signals (NM = number of masters)
//   Hbusreq   [NM]     per-master bus request
//   Hlock     [NM]     per-master lock request
//   Htrans_m  [2*NM]   per-master Htrans, master i at [2i+1:2i]
//   Haddr_m   [32*NM]  per-master address
//   Hwrite_m  [NM]     per-master write flag
//   Hwdata_m  [32*NM]  per-master write data
//   Hready             transfer complete (bridge Hreadyout)
//   Hgrant    [NM]     registered one-hot grant
//   Hmaster   [2]      registered address-phase owner
//   Hmastlock          registered, current address phase is locked
//   Htrans/Haddr/Hwrite  muxed from the address-phase owner
//   Hwdata               muxed from the data-phase owner
interface ahb_master_arbiter_if #(
    parameter int NM = 3
);
    logic [NM-1:0]      Hbusreq;
    logic [NM-1:0]      Hlock;
    logic [2*NM-1:0]    Htrans_m;
    logic [32*NM-1:0]   Haddr_m;
    logic [NM-1:0]      Hwrite_m;
    logic [32*NM-1:0]   Hwdata_m;
    logic               Hready;

    logic [NM-1:0]      Hgrant;
    logic [1:0]         Hmaster;
    logic               Hmastlock;
    logic [1:0]         Htrans;
    logic [31:0]        Haddr;
    logic               Hwrite;
    logic [31:0]        Hwdata;

    modport slave (
        input  Hbusreq, Hlock, Htrans_m, Haddr_m, Hwrite_m, Hwdata_m, Hready,
        output Hgrant, Hmaster, Hmastlock, Htrans, Haddr, Hwrite, Hwdata
    );

    modport master (
        output Hbusreq, Hlock, Htrans_m, Haddr_m, Hwrite_m, Hwdata_m, Hready,
        input  Hgrant, Hmaster, Hmastlock, Htrans, Haddr, Hwrite, Hwdata
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//
// Round-robin arbiter and multiplexer sharing the single AHB slave port of
// the AHB-to-APB bridge between up to four AHB masters. Grants are
// registered; address-phase ownership (Hmaster) and data-phase ownership
// (data_idx) follow the AHB pipeline, each advancing only on Hready=1
// edges. Supports locked transfers, a maximum-tenure preemption limit that
// never breaks a burst at a SEQ beat, and parking on master 0 when idle.
//
// Parameters
//   NM          number of masters, 2..4 (index width fixed at 2 bits)
//   MAX_TENURE  counted address-phase beats after which a waiting
//               requester may preempt an unlocked owner, 1..255
//
// Ports
//   Hclk    clock, all state changes on its rising edge
//   Hreset  asynchronous active-high reset
//   bus     ahb_master_arbiter_if.slave, requests in / grants and mux out
module ahb_master_arbiter #(
    parameter int NM         = 3,
    parameter int MAX_TENURE = 16
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    ahb_master_arbiter_if.slave  bus
);

    localparam logic [1:0] TRANS_SEQ  = 2'b11;
    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);

    // State
    logic [1:0]     grant_idx;
    logic [NM-1:0]  hgrant_q;
    logic [1:0]     hmaster_q;
    logic [1:0]     data_idx;
    logic           hmastlock_q;
    logic [7:0]     tenure;

    // Current grantee's view of the request inputs
    logic           req_g;
    logic           lock_g;
    logic           seq_g;
    logic           others_req;

    // Arbitration result
    logic [1:0]     next_idx;
    logic [NM-1:0]  next_onehot;
    logic           found;
    logic [1:0]     cand;

    // Muxed bus
    logic [1:0]     htrans_mux;
    logic [31:0]    haddr_mux;
    logic           hwrite_mux;
    logic [31:0]    hwdata_mux;

    always_comb begin
        req_g      = 1'b0;
        lock_g     = 1'b0;
        seq_g      = 1'b0;
        others_req = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (grant_idx == 2'(i)) begin
                req_g  = bus.Hbusreq[i];
                lock_g = bus.Hlock[i];
                seq_g  = (bus.Htrans_m[2*i +: 2] == TRANS_SEQ);
            end else if (bus.Hbusreq[i]) begin
                others_req = 1'b1;
            end
        end
    end

    // Priority: locked owner, then owner within tenure (or mid-burst),
    // then round-robin search starting after the owner, then park on 0.
    always_comb begin
        next_idx = 2'd0;
        found    = 1'b0;
        cand     = 2'd0;
        if (req_g && lock_g) begin
            next_idx = grant_idx;
        end else if (req_g && !(tenure >= TENURE_MAX && others_req && !seq_g)) begin
            next_idx = grant_idx;
        end else begin
            // k runs 1..NM so the current owner is visited last
            for (int k = 1; k <= NM; k++) begin
                cand = 2'((int'(grant_idx) + k) % NM);
                for (int j = 0; j < NM; j++) begin
                    if (!found && cand == 2'(j) && bus.Hbusreq[j]) begin
                        found    = 1'b1;
                        next_idx = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        next_onehot = '0;
        for (int i = 0; i < NM; i++) begin
            next_onehot[i] = (next_idx == 2'(i));
        end
    end

    // Out-of-range indices select all zeros, which also forces Htrans IDLE.
    always_comb begin
        htrans_mux = 2'b00;
        haddr_mux  = 32'h0;
        hwrite_mux = 1'b0;
        hwdata_mux = 32'h0;
        for (int i = 0; i < NM; i++) begin
            if (hmaster_q == 2'(i)) begin
                htrans_mux = bus.Htrans_m[2*i +: 2];
                haddr_mux  = bus.Haddr_m[32*i +: 32];
                hwrite_mux = bus.Hwrite_m[i];
            end
            if (data_idx == 2'(i)) begin
                hwdata_mux = bus.Hwdata_m[32*i +: 32];
            end
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            grant_idx   <= 2'd0;
            hgrant_q    <= {{(NM-1){1'b0}}, 1'b1};
            hmaster_q   <= 2'd0;
            data_idx    <= 2'd0;
            hmastlock_q <= 1'b0;
            tenure      <= 8'd0;
        end else if (bus.Hready) begin
            grant_idx   <= next_idx;
            hgrant_q    <= next_onehot;
            // Pipeline shifts use the pre-edge values so the old owner
            // always keeps its data phase for exactly one more beat.
            hmaster_q   <= grant_idx;
            data_idx    <= hmaster_q;
            hmastlock_q <= req_g & lock_g;
            if (next_idx != grant_idx) begin
                tenure <= 8'd0;
            end else if (hmaster_q == grant_idx && htrans_mux[1] && tenure < TENURE_MAX) begin
                // htrans_mux[1] set means NONSEQ or SEQ
                tenure <= tenure + 8'd1;
            end
        end
    end

    assign bus.Hgrant    = hgrant_q;
    assign bus.Hmaster   = hmaster_q;
    assign bus.Hmastlock = hmastlock_q;
    assign bus.Htrans    = htrans_mux;
    assign bus.Haddr     = haddr_mux;
    assign bus.Hwrite    = hwrite_mux;
    assign bus.Hwdata    = hwdata_mux;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter
//
// Self-checking bench for ahb_master_arbiter with NM=3, MAX_TENURE=4.
// Each applied vector carries its inputs and the expected post-edge grant,
// Hmaster, Hmastlock and data-phase owner; the expectation is queued when
// the vector is driven and popped and compared after the clock edge.
module tb_ahb_master_arbiter;

    localparam int NM = 3;

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [5:0] trans;
        logic       rdy;
        logic [2:0] grant;
        logic [1:0] hm;
        logic       ml;
        logic [1:0] di;
    } vec_t;

    logic Hclk = 1'b0;
    logic Hreset;

    ahb_master_arbiter_if #(.NM(NM)) bus ();

    ahb_master_arbiter #(.NM(NM), .MAX_TENURE(4)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    always #5 Hclk = ~Hclk;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sbq[$];
    logic [2:0] hwrite_pat = 3'b101;

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hD000_0000 + 32'(i) * 32'h111;
    endfunction

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] lock,
                                input logic [5:0] trans, input logic rdy,
                                input logic [2:0] grant, input logic [1:0] hm,
                                input logic ml, input logic [1:0] di);
        vec_t v;
        v.req = req; v.lock = lock; v.trans = trans; v.rdy = rdy;
        v.grant = grant; v.hm = hm; v.ml = ml; v.di = di;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input vec_t e, input string tag);
        logic [1:0] exp_trans;
        exp_trans = e.trans[2*e.hm +: 2];
        check({tag, ".grant"},     32'(bus.Hgrant),    32'(e.grant));
        check({tag, ".hmaster"},   32'(bus.Hmaster),   32'(e.hm));
        check({tag, ".hmastlock"}, 32'(bus.Hmastlock), 32'(e.ml));
        check({tag, ".haddr"},     bus.Haddr,          addr_of(int'(e.hm)));
        check({tag, ".htrans"},    32'(bus.Htrans),    32'(exp_trans));
        check({tag, ".hwrite"},    32'(bus.Hwrite),    32'(hwrite_pat[e.hm]));
        check({tag, ".hwdata"},    bus.Hwdata,         wdata_of(int'(e.di)));
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        bus.Hbusreq  = v.req;
        bus.Hlock    = v.lock;
        bus.Htrans_m = v.trans;
        bus.Hready   = v.rdy;
        sbq.push_back(v);
        @(posedge Hclk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.queue: got empty expected one entry", tag);
        end else begin
            e = sbq.pop_front();
            check_outputs(e, tag);
        end
    endtask

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // idle / single handover to master 1 / park
        tbl[0]  = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
        tbl[1]  = mk(3'b010, 3'b000, 6'b001000, 1'b1, 3'b010, 2'd0, 1'b0, 2'd0);
        tbl[2]  = mk(3'b010, 3'b000, 6'b001000, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
        tbl[3]  = mk(3'b010, 3'b000, 6'b001000, 1'b1, 3'b010, 2'd1, 1'b0, 2'd1);
        tbl[4]  = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd1, 1'b0, 2'd1);
        tbl[5]  = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd1);
        tbl[6]  = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
        // round robin from owner 0, owner drops its request each beat
        tbl[7]  = mk(3'b110, 3'b000, 6'b101010, 1'b1, 3'b010, 2'd0, 1'b0, 2'd0);
        tbl[8]  = mk(3'b101, 3'b000, 6'b101010, 1'b1, 3'b100, 2'd1, 1'b0, 2'd0);
        tbl[9]  = mk(3'b011, 3'b000, 6'b101010, 1'b1, 3'b001, 2'd2, 1'b0, 2'd1);
        tbl[10] = mk(3'b110, 3'b000, 6'b101010, 1'b1, 3'b010, 2'd0, 1'b0, 2'd2);
        tbl[11] = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd1, 1'b0, 2'd0);
        tbl[12] = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd1);
        tbl[13] = mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);

        Hreset       = 1'b1;
        bus.Hbusreq  = '0;
        bus.Hlock    = '0;
        bus.Htrans_m = '0;
        bus.Hready   = 1'b1;
        bus.Hwrite_m = hwrite_pat;
        for (int i = 0; i < NM; i++) begin
            bus.Haddr_m[32*i +: 32]  = addr_of(i);
            bus.Hwdata_m[32*i +: 32] = wdata_of(i);
        end
        repeat (2) @(posedge Hclk);
        #1;
        check("rst.grant",   32'(bus.Hgrant),    32'h1);
        check("rst.hmaster", 32'(bus.Hmaster),   32'h0);
        check("rst.lock",    32'(bus.Hmastlock), 32'h0);
        check("rst.haddr",   bus.Haddr,          addr_of(0));
        check("rst.hwdata",  bus.Hwdata,         wdata_of(0));
        Hreset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // tenure preemption, master 0 on NONSEQ singles, master 2 waiting
        for (int i = 0; i < 4; i++) begin
            apply(mk(3'b101, 3'b000, 6'b000010, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0),
                  $sformatf("tenA%0d", i));
        end
        apply(mk(3'b101, 3'b000, 6'b000010, 1'b1, 3'b100, 2'd0, 1'b0, 2'd0), "tenA_move");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd2, 1'b0, 2'd0), "parkA0");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd2), "parkA1");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0), "parkA2");

        // same with master 0 on SEQ beats: preemption waits for NONSEQ
        for (int i = 0; i < 6; i++) begin
            apply(mk(3'b101, 3'b000, 6'b000011, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0),
                  $sformatf("tenB%0d", i));
        end
        apply(mk(3'b101, 3'b000, 6'b000010, 1'b1, 3'b100, 2'd0, 1'b0, 2'd0), "tenB_move");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd2, 1'b0, 2'd0), "parkB0");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd2), "parkB1");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0), "parkB2");

        // locked master 1 for 40 beats with master 0 requesting
        apply(mk(3'b010, 3'b010, 6'b001010, 1'b1, 3'b010, 2'd0, 1'b0, 2'd0), "lock_get");
        for (int i = 0; i < 40; i++) begin
            apply(mk(3'b011, 3'b010, 6'b001010, 1'b1, 3'b010, 2'd1, 1'b1,
                     (i == 0) ? 2'd0 : 2'd1), $sformatf("lock%0d", i));
        end
        apply(mk(3'b001, 3'b000, 6'b001010, 1'b1, 3'b001, 2'd1, 1'b0, 2'd1), "lock_drop");

        // handover to master 2 interrupted by a 5-cycle stall
        apply(mk(3'b100, 3'b000, 6'b000000, 1'b1, 3'b100, 2'd0, 1'b0, 2'd1), "stall_pre");
        for (int i = 0; i < 5; i++) begin
            apply(mk(3'b010, 3'b000, 6'b000000, 1'b0, 3'b100, 2'd0, 1'b0, 2'd1),
                  $sformatf("stall%0d", i));
        end
        apply(mk(3'b100, 3'b000, 6'b000000, 1'b1, 3'b100, 2'd2, 1'b0, 2'd0), "resume0");
        apply(mk(3'b100, 3'b000, 6'b000000, 1'b1, 3'b100, 2'd2, 1'b0, 2'd2), "resume1");

        // lock up master 1 again, then reset asynchronously mid-transfer
        apply(mk(3'b010, 3'b010, 6'b001000, 1'b1, 3'b010, 2'd2, 1'b0, 2'd2), "prerst0");
        apply(mk(3'b010, 3'b010, 6'b001000, 1'b1, 3'b010, 2'd1, 1'b1, 2'd2), "prerst1");
        bus.Hbusreq = 3'b110;
        #3;
        Hreset = 1'b1;
        #1;
        check("arst.grant",   32'(bus.Hgrant),    32'h1);
        check("arst.hmaster", 32'(bus.Hmaster),   32'h0);
        check("arst.lock",    32'(bus.Hmastlock), 32'h0);
        check("arst.haddr",   bus.Haddr,          addr_of(0));
        check("arst.htrans",  32'(bus.Htrans),    32'h0);
        check("arst.hwdata",  bus.Hwdata,         wdata_of(0));
        @(posedge Hclk);
        #1;
        Hreset = 1'b0;
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0), "postrst0");
        apply(mk(3'b000, 3'b000, 6'b000000, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0), "postrst1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
